alu_serial_core: RTL

Parametrised serial-packet ALU. It deserialises operand and control packets from a one-bit input line, checks framing and CRC, and computes `C = B op A` at `DATA_W` bits. It serialises the result, or an error report, onto a one-bit output line. It extends the fixed-width serial ALU with width generalisation, an XOR mode and a `busy` indication, and it is the DUT for the lab testbench that uses the team's ALU package enums.

---
 rtl/alu_serial_core_if.sv | 10 +
 rtl/alu_serial_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_core_if.sv
// Serial request/response lines of alu_serial_core.
// The bench drives the master side and the core sits on the slave side.
interface alu_serial_core_if;
    logic sin;
    logic sout;
    logic busy;

    modport master (output sin, input sout, input busy);
    modport slave  (input sin, output sout, output busy);
endinterface

// File: rtl/alu_serial_core.sv
// Serial-packet ALU: deserialises B, A and a CTL packet, checks framing and CRC4,
// computes C = B op A and serialises the result plus flags/CRC3, or an error report.
module alu_serial_core #(
    parameter int DATA_W = 32,
    parameter int BYTES  = DATA_W / 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_serial_core_if.slave bus
);
    localparam int NPKT  = 2 * BYTES;
    localparam int PKT_W = $clog2(NPKT + 1);
    localparam int TX_W  = 11 * (BYTES + 1);
    localparam int TXC_W = $clog2(TX_W + 1);

    localparam logic [PKT_W-1:0] PKT_LAST   = PKT_W'(NPKT);
    localparam logic [TXC_W-1:0] TX_LEN_OK  = TXC_W'(TX_W);
    localparam logic [TXC_W-1:0] TX_LEN_ERR = TXC_W'(11);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_IDLE_GAP, S_CHECK, S_CALC, S_ERR, S_TX
    } state_t;

    // CRC4 x^4+x+1 and CRC3 x^3+x+1, init 0, MSB first
    function automatic logic [3:0] crc4_f(input logic [2*DATA_W+3:0] msg);
        logic [3:0] c;
        logic       fb;
        c = '0;
        for (int i = 2*DATA_W+3; i >= 0; i--) begin
            fb = c[3] ^ msg[i];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    function automatic logic [2:0] crc3_f(input logic [DATA_W+4:0] msg);
        logic [2:0] c;
        logic       fb;
        c = '0;
        for (int i = DATA_W+4; i >= 0; i--) begin
            fb = c[2] ^ msg[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [PKT_W-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic                type_q, type_d;
    logic [7:0]          pay_q, pay_d;
    logic [2*DATA_W-1:0] opnd_q, opnd_d;
    logic [2:0]          op_q, op_d;
    logic [3:0]          crc_rx_q, crc_rx_d;
    logic [2:0]          err_q, err_d;
    logic                hold_q, hold_d;
    logic [TX_W-1:0]     tx_sr_q, tx_sr_d;
    logic [TXC_W-1:0]    tx_cnt_q, tx_cnt_d;
    logic                sout_q, sout_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   b_opnd, a_opnd, a_eff, res;
    logic [DATA_W:0]     sum_w;
    logic                carry, ovf, is_arith, op_ok, pkt_full, err_par;
    logic [3:0]          flags;
    logic [2:0]          crc3;
    logic [TX_W-1:0]     ok_frame, err_frame;

    assign b_opnd   = opnd_q[2*DATA_W-1 -: DATA_W];
    assign a_opnd   = opnd_q[DATA_W-1:0];
    assign pkt_full = (pkt_cnt_q == PKT_LAST);
    assign op_ok    = op_q inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB};
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_comb begin
        sum_w = '0;
        res   = '0;
        carry = 1'b0;
        a_eff = (op_q == OP_SUB) ? ~a_opnd : a_opnd;
        case (op_q)
            OP_AND: res = b_opnd & a_opnd;
            OP_OR:  res = b_opnd | a_opnd;
            OP_XOR: res = b_opnd ^ a_opnd;
            OP_ADD: begin
                sum_w = {1'b0, b_opnd} + {1'b0, a_opnd};
                res   = sum_w[DATA_W-1:0];
                carry = sum_w[DATA_W];
            end
            OP_SUB: begin
                // top bit of the widened difference is the unsigned borrow
                sum_w = {1'b0, b_opnd} - {1'b0, a_opnd};
                res   = sum_w[DATA_W-1:0];
                carry = sum_w[DATA_W];
            end
            default: res = '0;
        endcase
        ovf   = is_arith && (b_opnd[DATA_W-1] == a_eff[DATA_W-1]) &&
                (res[DATA_W-1] != b_opnd[DATA_W-1]);
        flags = {carry, ovf, (res == '0), res[DATA_W-1]};
        crc3  = crc3_f({res, 1'b0, flags});
    end

    // Response frames, first transmitted bit in the MSB
    always_comb begin
        ok_frame = '1;
        for (int i = 0; i < BYTES; i++)
            ok_frame[TX_W-1-11*i -: 11] = {2'b00, res[DATA_W-1-8*i -: 8], 1'b1};
        ok_frame[10:0] = {2'b01, 1'b0, flags, crc3, 1'b1};
        err_par   = ^{1'b1, err_q, err_q};
        err_frame = {2'b01, 1'b1, err_q, err_q, err_par, 1'b1, {(TX_W-11){1'b1}}};
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        type_d    = type_q;
        pay_d     = pay_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        crc_rx_d  = crc_rx_q;
        err_d     = err_q;
        hold_d    = hold_q;
        tx_sr_d   = tx_sr_q;
        tx_cnt_d  = tx_cnt_q;
        sout_d    = sout_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE, S_IDLE_GAP: begin
                if (!bus.sin) begin
                    state_d   = S_RX;
                    bit_cnt_d = '0;
                end
            end
            S_RX: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    type_d = bus.sin;
                end else if (bit_cnt_q != 4'd9) begin
                    pay_d = {pay_q[6:0], bus.sin};
                end else begin
                    bit_cnt_d = '0;
                    // hold_q pads the direct error path to the same latency as CHECK
                    if (!bus.sin || (type_q != pkt_full)) begin
                        err_d   = ERR_DATA;
                        hold_d  = 1'b1;
                        state_d = S_ERR;
                    end else if (!type_q) begin
                        opnd_d    = {opnd_q[2*DATA_W-9:0], pay_q};
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
                        state_d   = S_IDLE_GAP;
                    end else begin
                        op_d     = pay_q[6:4];
                        crc_rx_d = pay_q[3:0];
                        state_d  = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                hold_d = 1'b0;
                if (crc4_f({opnd_q, 1'b1, op_q}) != crc_rx_q) begin
                    err_d   = ERR_CRC;
                    state_d = S_ERR;
                end else if (!op_ok) begin
                    err_d   = ERR_OP;
                    state_d = S_ERR;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                tx_sr_d  = ok_frame;
                tx_cnt_d = TX_LEN_OK;
                state_d  = S_TX;
            end
            S_ERR: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    tx_sr_d  = err_frame;
                    tx_cnt_d = TX_LEN_ERR;
                    state_d  = S_TX;
                end
            end
            S_TX: begin
                if (tx_cnt_q != '0) begin
                    sout_d   = tx_sr_q[TX_W-1];
                    tx_sr_d  = {tx_sr_q[TX_W-2:0], 1'b1};
                    tx_cnt_d = tx_cnt_q - 1'b1;
                    busy_d   = 1'b1;
                end else begin
                    sout_d    = 1'b1;
                    busy_d    = 1'b0;
                    pkt_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            pkt_cnt_q <= '0;
            opnd_q    <= '0;
            err_q     <= '0;
            hold_q    <= 1'b0;
            tx_cnt_q  <= '0;
            sout_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            opnd_q    <= opnd_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            tx_cnt_q  <= tx_cnt_d;
            sout_q    <= sout_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        type_q   <= type_d;
        pay_q    <= pay_d;
        op_q     <= op_d;
        crc_rx_q <= crc_rx_d;
        tx_sr_q  <= tx_sr_d;
    end

    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
endmodule
